// File: rtl/merge_pkg.sv
// Shared constants for the channel merge buffer: channel ids and output-register states.
package merge_pkg;
  localparam logic CHAN_0 = 1'b0;
  localparam logic CHAN_1 = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
endpackage

// File: rtl/merge_fifo.sv
// Synchronous FIFO, DATA_W x FIFO_DEPTH. Pointers carry one extra wrap bit.
// The caller must not push when full or pop when empty.
module merge_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Full when the wrap bits differ but the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end
endmodule

// File: rtl/channel_merge_buffer.sv
// Buffers both distributor channels in per-channel FIFOs and merges them round-robin
// onto one valid/ready stream. Define MERGE_DROP_CNT_EN to add per-channel drop counters.
module channel_merge_buffer
  import merge_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
`ifdef MERGE_DROP_CNT_EN
  ,
  parameter int CNT_W      = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in0_full,
  output logic              in1_full,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_chan,
  output logic              drop_flag
`ifdef MERGE_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]  drop0_cnt,
  output logic [CNT_W-1:0]  drop1_cnt
`endif
);
  logic              push0, push1, pop0, pop1, drop0, drop1;
  logic              empty0, empty1;
  logic [DATA_W-1:0] head0, head1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_chan_q, out_chan_d;
  logic              rr_last_q, rr_last_d;
  logic              drop_flag_q, drop_flag_d;
  logic              load_en, grant;

  // Full status is the pre-edge value, so a write while full drops even if a pop frees a slot.
  assign push0 = in0_valid & ~in0_full;
  assign push1 = in1_valid & ~in1_full;
  assign drop0 = in0_valid & in0_full;
  assign drop1 = in1_valid & in1_full;

  merge_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .push_data(in0_data), .pop(pop0),
    .pop_data(head0), .full(in0_full), .empty(empty0)
  );

  merge_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .push_data(in1_data), .pop(pop1),
    .pop_data(head1), .full(in1_full), .empty(empty1)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_last_d   = rr_last_q;
    drop_flag_d = drop_flag_q | drop0 | drop1;
    pop0        = 1'b0;
    pop1        = 1'b0;
    load_en     = (state_q == ST_EMPTY) | out_ready;

    // On a tie the channel not granted last time wins.
    if (!empty0 && !empty1) grant = ~rr_last_q;
    else if (!empty1)       grant = CHAN_1;
    else                    grant = CHAN_0;

    if (load_en) begin
      if (!empty0 || !empty1) begin
        state_d    = ST_HOLD;
        out_chan_d = grant;
        rr_last_d  = grant;
        out_data_d = (grant == CHAN_1) ? head1 : head0;
        pop0       = (grant == CHAN_0);
        pop1       = (grant == CHAN_1);
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_chan_q  <= CHAN_0;
      rr_last_q   <= CHAN_1;
      drop_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_last_q   <= rr_last_d;
      drop_flag_q <= drop_flag_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign drop_flag = drop_flag_q;

`ifdef MERGE_DROP_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drop0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (drop1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign drop0_cnt = cnt0_q;
  assign drop1_cnt = cnt1_q;
`endif
endmodule

// File: tb/tb_channel_merge_buffer.sv
// Self-checking bench for channel_merge_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_channel_merge_buffer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_full, in1_full, out_valid, out_chan, drop_flag;
  logic [7:0] out_data;
`ifdef MERGE_DROP_CNT_EN
  logic [7:0] drop0_cnt, drop1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_valid, m_chan, m_rr, m_drop;
  logic [7:0] m_data;
  int         m_cnt0, m_cnt1;

  channel_merge_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in0_full(in0_full), .in1_full(in1_full),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan),
    .drop_flag(drop_flag)
`ifdef MERGE_DROP_CNT_EN
    , .drop0_cnt(drop0_cnt), .drop1_cnt(drop1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_chan  = 1'b0;
    m_rr    = 1'b1;
    m_drop  = 1'b0;
    m_cnt0  = 0;
    m_cnt1  = 0;
  endtask

  task automatic model_edge(input logic v0, input logic [7:0] d0, input logic v1,
                            input logic [7:0] d1, input logic rdy);
    bit f0, f1, ch;
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    if (v0 && f0) begin m_drop = 1'b1; if (m_cnt0 < 255) m_cnt0++; end
    if (v1 && f1) begin m_drop = 1'b1; if (m_cnt1 < 255) m_cnt1++; end
    if (!m_valid || rdy) begin
      if (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() > 0 && q1.size() > 0) ch = !m_rr;
        else                                ch = (q1.size() > 0);
        m_data  = ch ? q1.pop_front() : q0.pop_front();
        m_chan  = ch;
        m_rr    = ch;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (v0 && !f0) q0.push_back(d0);
    if (v1 && !f1) q1.push_back(d1);
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_chan",  32'(out_chan),  32'(m_chan));
    check("in0_full",  32'(in0_full),  32'(q0.size() == DEPTH));
    check("in1_full",  32'(in1_full),  32'(q1.size() == DEPTH));
    check("drop_flag", 32'(drop_flag), 32'(m_drop));
`ifdef MERGE_DROP_CNT_EN
    check("drop0_cnt", 32'(drop0_cnt), 32'(m_cnt0));
    check("drop1_cnt", 32'(drop1_cnt), 32'(m_cnt1));
`endif
  endtask

  // Called just after a negedge: drive, let one rising edge pass, compare at the next negedge.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                      input logic [7:0] d1, input logic rdy);
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = rdy;
    @(posedge clk);
    model_edge(v0, d0, v1, d1, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in0_full",  32'(in0_full),  32'd0);
    check("rst_in1_full",  32'(in1_full),  32'd0);
    check("rst_drop_flag", 32'(drop_flag), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rr_exp[8];
    logic [7:0] dd;

    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single word
    step(1, 8'hFF, 0, 8'h00, 1);
    check("single_lat_valid", 32'(out_valid), 32'd0);
    step(0, 8'h00, 0, 8'h00, 1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hFF);
    check("single_chan",  32'(out_chan),  32'd0);
    step(0, 8'h00, 0, 8'h00, 1);
    check("single_drain", 32'(out_valid), 32'd0);

    // Tie: ch0 wins first, then ch1 back to back
    do_reset();
    step(1, 8'h11, 1, 8'h22, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    check("tie_first_data", 32'(out_data), 32'h11);
    check("tie_first_chan", 32'(out_chan), 32'd0);
    step(0, 8'h00, 0, 8'h00, 1);
    check("tie_second_valid", 32'(out_valid), 32'd1);
    check("tie_second_data",  32'(out_data),  32'h22);
    check("tie_second_chan",  32'(out_chan),  32'd1);

    // Stall until full, then one dropped write, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) step(0, 8'h00, 1, 8'(i), 0);
    check("stall_full",    32'(in1_full),  32'd1);
    check("stall_no_drop", 32'(drop_flag), 32'd0);
    step(0, 8'h00, 1, 8'h06, 0);
    check("stall_drop", 32'(drop_flag), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  32'(out_data),  32'(i));
      check("drain_chan",  32'(out_chan),  32'd1);
      step(0, 8'h00, 0, 8'h00, 1);
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drop_sticky", 32'(drop_flag), 32'd1);

    // Round robin across two loaded FIFOs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rr_exp[2*i]   = 8'hA0 + 8'(i);
      rr_exp[2*i+1] = 8'hB0 + 8'(i);
      step(1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 0);
    end
    for (int i = 0; i < 8; i++) begin
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_data",  32'(out_data),  32'(rr_exp[i]));
      check("rr_chan",  32'(out_chan),  32'(i % 2));
      step(0, 8'h00, 0, 8'h00, 1);
    end
    check("rr_empty", 32'(out_valid), 32'd0);

`ifdef MERGE_DROP_CNT_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(i), 1, 8'(i + 16), 0);
    step(1, 8'h04, 0, 8'h00, 0);
    check("cnt_pre0", 32'(drop0_cnt), 32'd0);
    check("cnt_pre1", 32'(drop1_cnt), 32'd0);
    step(1, 8'h05, 1, 8'h15, 0);
    step(1, 8'h06, 0, 8'h00, 0);
    step(1, 8'h07, 0, 8'h00, 0);
    check("cnt_drop0", 32'(drop0_cnt), 32'd3);
    check("cnt_drop1", 32'(drop1_cnt), 32'd1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) step(1, 8'h5A, 0, 8'h00, 0);
    check("cnt_sat", 32'(drop0_cnt), 32'd255);
`endif

    // Random traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        check("midrst_model_empty", 32'(q0.size() + q1.size()), 32'd0);
      end
      dd = 8'($urandom);
      step($urandom_range(0, 9) < 6, dd, $urandom_range(0, 9) < 6, 8'($urandom),
           $urandom_range(0, 9) < 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
